enc_1_act: RTL and testbench
============================

# enc_1_act

Activation stage directly downstream of the 10→6 encoder layer. It captures the layer's 6-element output vector with a valid/ready handshake and applies the activation element-by-element, one per cycle, through a single shared activation unit. It then presents the activated vector to the next layer with a valid/ready handshake. The activation is either a shift-only piecewise-linear (PLAN) sigmoid or a ReLU, and no multipliers are used.

## Interface
- BITSIZE, 24: signed two's-complement word width.
- FRAC, 16: fractional bits. 1.0 = 0x010000 at defaults.
- N, 6: vector length.
- ACT, 0: activation select. 0 = PLAN sigmoid, 1 = ReLU.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream vector on x is valid.
- in_ready  output  1  block can accept a vector.
- x  input  BITSIZE*N  input vector; element i is at x[BITSIZE*i +: BITSIZE].
- out_valid  output  1  y holds a complete activated vector.
- out_ready  input  1  downstream consumes y.
- y  output  BITSIZE*N  activated vector, same packing as x.

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - When in_valid=1, capture all of x into the input buffer, set idx=0, and go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, write y[idx] <= act(buf[idx]), then idx <= idx+1.
  - After the write of element N-1, go to HOLD.
- HOLD:
  - out_valid=1 and y is stable.
  - When out_ready=1, go to IDLE. out_valid is 0 in the following cycle.
  - in_valid is ignored; in_ready stays 0.
- Handshake rules:
  - A transfer occurs only on an edge where valid and ready are both 1.
  - x need not be held after the capture edge.
- PLAN sigmoid, with a = |v|:
  - a >= 5.0 (0x050000): s = 1.0 (0x010000).
  - 2.375 (0x026000) <= a < 5.0: s = (a>>5) + 0.84375 (0x00D800).
  - 1.0 <= a < 2.375: s = (a>>3) + 0.625 (0x00A000).
  - a < 1.0: s = (a>>2) + 0.5 (0x008000).
  - Result: v >= 0 gives s; v < 0 gives 1.0 − s.
  - Shifts are logical on non-negative a, truncating. The output is always in [0, 0x010000].
  - |−2^(BITSIZE−1)| saturates to 2^(BITSIZE−1)−1.
- ReLU: v < 0 gives 0, otherwise v unchanged. No saturation is needed.
- Thresholds and constants are derived from FRAC, not hard-coded to 16.

## Timing
- Reset values: state=IDLE, idx=0, buffer=0, y=0, out_valid=0, in_ready=1 (combinational from state).
- Latency: capture on edge E0; elements are written on edges E1..EN; out_valid=1 from the cycle after EN (N cycles after capture).
- Throughput: at best one vector per N+2 cycles (capture, N run cycles, one HOLD cycle).
- The activation unit is purely combinational between the buffer mux and the y register, so there is one register stage per element.
- y elements change only during RUN. While out_valid=1, y must not change.
- Reset mid-RUN or mid-HOLD: everything returns to reset values immediately, the partial result is discarded, and no out_valid pulse is produced.
- out_ready asserted while not in HOLD has no effect.
- in_valid and out_ready both high in HOLD: only the output transfer occurs. The input is accepted no earlier than the next IDLE cycle.

## Structure
- Shared package holds:
  - FRAC-derived constants: ONE, THR_5, THR_2375, C_084375, C_0625, C_05.
  - The state enum (IDLE/RUN/HOLD).
  - ACT encodings.
- Sub-module `plan_sigmoid`: combinational, one BITSIZE-bit input to one output. Parameterised by BITSIZE and FRAC, with ACT selecting the ReLU bypass. It is instantiated once.
- The top level contains the FSM, the idx counter (clog2(N) bits), the input buffer, and the y register file.

## Test plan
- Sigmoid points: x = {0, 0x010000, 0xFF0000 (−1.0), 0x030000, 0x008000, 0x060000}, with out_ready held at 1. Required: y = {0x008000, 0x00C000, 0x004000, 0x00F000, 0x00A000, 0x010000}, and out_valid rises exactly N cycles after the capture edge.
- Saturation: elements 0xFA0000 (−6.0), 0x800000, and 0x7FFFFF. Required: 0x000000, 0x000000, and 0x010000.
- ReLU (ACT=1): x = {0xFFFFFF, 0x123456, 0, 0x800000, 1, 0x7FFFFF}. Required: y = {0, 0x123456, 0, 0, 1, 0x7FFFFF}.
- Backpressure:
  - Hold out_ready=0 for 20 cycles: out_valid and y stay stable, in_ready=0, and a new vector presented on in_valid is not captured.
  - Then release out_ready: the new vector is captured one cycle after the return to IDLE.
- Reset at the 3rd RUN cycle: all outputs return to reset values and y=0. The next vector completes correctly, with no stale elements.
- Back-to-back vectors with in_valid held high: each vector is accepted every N+2 cycles, and the results match the golden model in order.

Source files
------------

// File: rtl/enc_1_act_pkg.sv
// Shared types and FRAC-scaled constants for the encoder activation stage.
// The constant helpers assume FRAC >= 5 so every constant is an exact shift.
package enc_1_act_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int ACT_PLAN = 0;
  localparam int ACT_RELU = 1;

  localparam int FRAC_DEFAULT = 16;

  function automatic longint one_c(input int frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint thr_5_c(input int frac);
    return longint'(5) << frac;
  endfunction

  // 2.375 = 19/8
  function automatic longint thr_2375_c(input int frac);
    return longint'(19) << (frac - 3);
  endfunction

  // 0.84375 = 27/32
  function automatic longint c_084375_c(input int frac);
    return longint'(27) << (frac - 5);
  endfunction

  function automatic longint c_0625_c(input int frac);
    return longint'(5) << (frac - 3);
  endfunction

  function automatic longint c_05_c(input int frac);
    return longint'(1) << (frac - 1);
  endfunction

  localparam longint ONE      = one_c(FRAC_DEFAULT);
  localparam longint THR_5    = thr_5_c(FRAC_DEFAULT);
  localparam longint THR_2375 = thr_2375_c(FRAC_DEFAULT);
  localparam longint C_084375 = c_084375_c(FRAC_DEFAULT);
  localparam longint C_0625   = c_0625_c(FRAC_DEFAULT);
  localparam longint C_05     = c_05_c(FRAC_DEFAULT);

endpackage

// File: rtl/enc_1_act_plan_sigmoid.sv
// Combinational shift-only PLAN sigmoid with an optional ReLU bypass.
module plan_sigmoid
  import enc_1_act_pkg::*;
#(
  parameter int BITSIZE = 24,
  parameter int FRAC    = 16,
  parameter int ACT     = 0
) (
  input  logic [BITSIZE-1:0] v,
  output logic [BITSIZE-1:0] s
);

  localparam logic [BITSIZE-1:0] K_ONE      = BITSIZE'(one_c(FRAC));
  localparam logic [BITSIZE-1:0] K_THR_5    = BITSIZE'(thr_5_c(FRAC));
  localparam logic [BITSIZE-1:0] K_THR_2375 = BITSIZE'(thr_2375_c(FRAC));
  localparam logic [BITSIZE-1:0] K_C_084375 = BITSIZE'(c_084375_c(FRAC));
  localparam logic [BITSIZE-1:0] K_C_0625   = BITSIZE'(c_0625_c(FRAC));
  localparam logic [BITSIZE-1:0] K_C_05     = BITSIZE'(c_05_c(FRAC));
  localparam logic [BITSIZE-1:0] MOST_NEG   = {1'b1, {(BITSIZE-1){1'b0}}};
  localparam logic [BITSIZE-1:0] MOST_POS   = {1'b0, {(BITSIZE-1){1'b1}}};

  logic                neg;
  logic [BITSIZE-1:0]  a;
  logic [BITSIZE-1:0]  s_pos;
  logic [BITSIZE-1:0]  sig;
  logic [BITSIZE-1:0]  relu;

  // a is always non-negative, so the threshold compares can stay unsigned
  always_comb begin
    neg   = v[BITSIZE-1];
    a     = v;
    s_pos = '0;
    sig   = '0;
    relu  = '0;
    if (neg) begin
      a = (v == MOST_NEG) ? MOST_POS : -v;
    end
    if (a >= K_THR_5) begin
      s_pos = K_ONE;
    end else if (a >= K_THR_2375) begin
      s_pos = (a >> 5) + K_C_084375;
    end else if (a >= K_ONE) begin
      s_pos = (a >> 3) + K_C_0625;
    end else begin
      s_pos = (a >> 2) + K_C_05;
    end
    sig  = neg ? (K_ONE - s_pos) : s_pos;
    relu = neg ? '0 : v;
    s    = (ACT == ACT_RELU) ? relu : sig;
  end

endmodule

// File: rtl/enc_1_act.sv
// Activation stage after the 10->6 encoder layer: captures a vector, activates
// one element per cycle through a single shared unit, then holds the result.
module enc_1_act
  import enc_1_act_pkg::*;
#(
  parameter int BITSIZE = 24,
  parameter int FRAC    = 16,
  parameter int N       = 6,
  parameter int ACT     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITSIZE*N-1:0] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITSIZE*N-1:0] y
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [BITSIZE-1:0] in_buf [N];
  logic [BITSIZE-1:0] y_q    [N];
  logic [BITSIZE-1:0] act_in;
  logic [BITSIZE-1:0] act_out;

  assign act_in   = in_buf[idx];
  assign in_ready = (state == IDLE);

  plan_sigmoid #(
    .BITSIZE (BITSIZE),
    .FRAC    (FRAC),
    .ACT     (ACT)
  ) u_act (
    .v (act_in),
    .s (act_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        in_buf[i] <= '0;
        y_q[i]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) begin
              in_buf[i] <= x[BITSIZE*i +: BITSIZE];
            end
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          y_q[idx] <= act_out;
          if (idx == LAST) begin
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // in_valid is deliberately ignored here; a new vector waits for IDLE
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign y[BITSIZE*g +: BITSIZE] = y_q[g];
  end

endmodule

// File: tb/tb_enc_1_act.sv
// Directed self-checking bench for enc_1_act; a sigmoid and a ReLU instance
// share the same stimulus and are checked against hand-computed vectors.
module tb_enc_1_act;

  localparam int BITSIZE = 24;
  localparam int N       = 6;
  localparam int W       = BITSIZE * N;

  // Element 0 is the rightmost field of each concatenation
  localparam logic [W-1:0] VEC_SIG   = {24'h060000, 24'h008000, 24'h030000, 24'hFF0000, 24'h010000, 24'h000000};
  localparam logic [W-1:0] SIG_EXP   = {24'h010000, 24'h00A000, 24'h00F000, 24'h004000, 24'h00C000, 24'h008000};
  localparam logic [W-1:0] VEC_SAT   = {24'h000000, 24'h000000, 24'h000000, 24'h7FFFFF, 24'h800000, 24'hFA0000};
  localparam logic [W-1:0] SAT_EXP_S = {24'h008000, 24'h008000, 24'h008000, 24'h010000, 24'h000000, 24'h000000};
  localparam logic [W-1:0] SAT_EXP_R = {24'h000000, 24'h000000, 24'h000000, 24'h7FFFFF, 24'h000000, 24'h000000};
  localparam logic [W-1:0] VEC_RELU  = {24'h7FFFFF, 24'h000001, 24'h800000, 24'h000000, 24'h123456, 24'hFFFFFF};
  localparam logic [W-1:0] RELU_EXP  = {24'h7FFFFF, 24'h000001, 24'h000000, 24'h000000, 24'h123456, 24'h000000};
  localparam logic [W-1:0] VEC_B     = {24'hFF0001, 24'h00FFFF, 24'h026000, 24'h050000, 24'hFE0000, 24'h020000};
  localparam logic [W-1:0] B_EXP     = {24'h004001, 24'h00BFFF, 24'h00EB00, 24'h010000, 24'h002000, 24'h00E000};

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic         in_ready_s, out_valid_s;
  logic         in_ready_r, out_valid_r;
  logic [W-1:0] y_s, y_r;

  int compared   = 0;
  int mismatched = 0;
  int n;

  enc_1_act #(.BITSIZE(BITSIZE), .FRAC(16), .N(N), .ACT(0)) dut_sig (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .x         (x),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .y         (y_s)
  );

  enc_1_act #(.BITSIZE(BITSIZE), .FRAC(16), .N(N), .ACT(1)) dut_relu (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_r),
    .x         (x),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .y         (y_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one vector for a single capture edge, then scrambles x
  task automatic apply_stimulus(input logic [W-1:0] vec);
    x        = vec;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    x        = '1;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (out_valid_s !== 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check_output("reset_in_ready", W'(in_ready_s), W'(1));
    check_output("reset_out_valid", W'(out_valid_s), W'(0));
    check_output("reset_y_sig", y_s, '0);
    check_output("reset_y_relu", y_r, '0);

    // Sigmoid points with out_ready held high
    out_ready = 1'b1;
    apply_stimulus(VEC_SIG);
    check_output("run_in_ready", W'(in_ready_s), W'(0));
    wait_out(n);
    check_output("sig_latency", W'(n), W'(N));
    check_output("sig_y", y_s, SIG_EXP);
    step();
    check_output("sig_out_valid_drop", W'(out_valid_s), W'(0));
    check_output("sig_back_idle", W'(in_ready_s), W'(1));

    // Saturation and most-negative input
    apply_stimulus(VEC_SAT);
    wait_out(n);
    check_output("sat_latency", W'(n), W'(N));
    check_output("sat_y_sig", y_s, SAT_EXP_S);
    check_output("sat_y_relu", y_r, SAT_EXP_R);
    step();

    apply_stimulus(VEC_RELU);
    wait_out(n);
    check_output("relu_latency", W'(n), W'(N));
    check_output("relu_y", y_r, RELU_EXP);
    step();

    // Backpressure: result must freeze and a pending vector must wait
    out_ready = 1'b0;
    apply_stimulus(VEC_SIG);
    wait_out(n);
    check_output("bp_latency", W'(n), W'(N));
    x        = VEC_B;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_output("bp_out_valid", W'(out_valid_s), W'(1));
      check_output("bp_in_ready", W'(in_ready_s), W'(0));
      check_output("bp_y_stable", y_s, SIG_EXP);
    end
    out_ready = 1'b1;
    step();
    check_output("bp_release_valid", W'(out_valid_s), W'(0));
    check_output("bp_release_idle", W'(in_ready_s), W'(1));
    check_output("bp_release_y", y_s, SIG_EXP);
    step();
    check_output("bp_capture", W'(in_ready_s), W'(0));
    in_valid = 1'b0;
    x        = '1;
    wait_out(n);
    check_output("bp_b_latency", W'(n), W'(N));
    check_output("bp_b_y", y_s, B_EXP);
    step();

    // Asynchronous reset during the third RUN cycle
    apply_stimulus(VEC_SAT);
    step();
    step();
    reset = 1'b1;
    #1;
    check_output("rst_in_ready", W'(in_ready_s), W'(1));
    check_output("rst_out_valid", W'(out_valid_s), W'(0));
    check_output("rst_y_sig", y_s, '0);
    check_output("rst_y_relu", y_r, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) step();
    check_output("rst_no_pulse", W'(out_valid_s), W'(0));
    apply_stimulus(VEC_SIG);
    wait_out(n);
    check_output("rst_next_latency", W'(n), W'(N));
    check_output("rst_next_y", y_s, SIG_EXP);
    step();

    // Back-to-back with in_valid held high: captures N+2 cycles apart
    x        = VEC_SIG;
    in_valid = 1'b1;
    step();
    x = VEC_B;
    wait_out(n);
    check_output("b2b_latency0", W'(n), W'(N));
    check_output("b2b_y0", y_s, SIG_EXP);
    step();
    check_output("b2b_idle", W'(in_ready_s), W'(1));
    step();
    check_output("b2b_capture1", W'(in_ready_s), W'(0));
    in_valid = 1'b0;
    x        = '1;
    wait_out(n);
    check_output("b2b_latency1", W'(n), W'(N));
    check_output("b2b_y1", y_s, B_EXP);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
